// File: rtl/ins_cache.sv
// Direct-mapped instruction cache: hits answer one cycle after acceptance, misses issue one adapter fetch task.
// Define INS_CACHE_STATS_EN to add the hit_count/miss_count output ports.
module ins_cache #(
  parameter int CACHE_LINES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_ins,
  output logic [31:0] fetch_pc_out,
  output logic        try_start_insfetch_task,
  output logic [31:0] insfetch_addr,
  input  logic        insfetch_task_done,
  input  logic [31:0] insfetch_ins_full
`ifdef INS_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX = $clog2(CACHE_LINES);
  localparam int TW  = 31 - IDX;

  typedef enum logic {
    ST_IDLE,
    ST_MISS
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CACHE_LINES-1:0] r_valid;
  logic [TW-1:0]          r_tag  [CACHE_LINES];
  logic [31:0]            r_data [CACHE_LINES];

  logic [IDX-1:0] w_req_idx;
  logic [TW-1:0]  w_req_tag;
  logic [IDX-1:0] w_miss_idx;
  logic [TW-1:0]  w_miss_tag;
  logic           w_hit;
  logic           w_accept;
  logic           w_done;

  // Index at halfword granularity so compressed instructions get their own lines.
  assign w_req_idx  = fetch_pc[IDX:1];
  assign w_req_tag  = fetch_pc[31:IDX+1];
  assign w_miss_idx = insfetch_addr[IDX:1];
  assign w_miss_tag = insfetch_addr[31:IDX+1];
  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_accept   = (r_state == ST_IDLE) && fetch_req && rdy_in && !flush_pipline;
  assign w_done     = (r_state == ST_MISS) && insfetch_task_done && rdy_in && !flush_pipline;

  always_comb begin
    w_state_nxt             = r_state;
    fetch_ready             = (r_state == ST_IDLE);
    try_start_insfetch_task = (r_state == ST_MISS);
    if (rdy_in) begin
      if (flush_pipline) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (w_accept && !w_hit) w_state_nxt = ST_MISS;
          ST_MISS: if (w_done) w_state_nxt = ST_IDLE;
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fetch_valid   <= 1'b0;
      fetch_ins     <= 32'h0;
      fetch_pc_out  <= 32'h0;
      insfetch_addr <= 32'h0;
      r_valid       <= '0;
    end else if (rdy_in) begin
      fetch_valid <= 1'b0;
      if (w_accept) begin
        if (w_hit) begin
          fetch_valid  <= 1'b1;
          fetch_ins    <= r_data[w_req_idx];
          fetch_pc_out <= fetch_pc;
        end else begin
          insfetch_addr <= fetch_pc;
        end
      end
      if (w_done) begin
        fetch_valid          <= 1'b1;
        fetch_ins            <= insfetch_ins_full;
        fetch_pc_out         <= insfetch_addr;
        r_valid[w_miss_idx]  <= 1'b1;
      end
    end
  end

  // Tag/data need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (w_done) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= insfetch_ins_full;
    end
  end

`ifdef INS_CACHE_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else if (w_accept) begin
      if (w_hit) hit_count  <= hit_count + 32'd1;
      else       miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_cache.sv
// Scoreboard bench for ins_cache: expected responses are queued at request time and popped on fetch_valid.
module tb_ins_cache;

  localparam int LINES = 16;
  localparam int IDXB  = $clog2(LINES);

  logic        clk_in             = 1'b0;
  logic        rst_in             = 1'b0;
  logic        rdy_in             = 1'b1;
  logic        flush_pipline      = 1'b0;
  logic        fetch_req          = 1'b0;
  logic [31:0] fetch_pc           = 32'h0;
  logic        insfetch_task_done = 1'b0;
  logic [31:0] insfetch_ins_full  = 32'h0;

  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_ins;
  logic [31:0] fetch_pc_out;
  logic        try_start;
  logic [31:0] insfetch_addr;
`ifdef INS_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  ins_cache #(.CACHE_LINES(LINES)) dut (
    .clk_in                  (clk_in),
    .rst_in                  (rst_in),
    .rdy_in                  (rdy_in),
    .flush_pipline           (flush_pipline),
    .fetch_req               (fetch_req),
    .fetch_pc                (fetch_pc),
    .fetch_ready             (fetch_ready),
    .fetch_valid             (fetch_valid),
    .fetch_ins               (fetch_ins),
    .fetch_pc_out            (fetch_pc_out),
    .try_start_insfetch_task (try_start),
    .insfetch_addr           (insfetch_addr),
    .insfetch_task_done      (insfetch_task_done),
    .insfetch_ins_full       (insfetch_ins_full)
`ifdef INS_CACHE_STATS_EN
    ,
    .hit_count               (hit_count),
    .miss_count              (miss_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic        m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  int          m_hits   = 0;
  int          m_misses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    if (pc == 32'h100) return 32'h00A00093;
    if (pc == 32'h102) return 32'h00004501;
    return {pc[15:0] ^ 16'hBEEF, pc[15:0]};
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 1) & (LINES - 1));
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> (IDXB + 1)));
  endfunction

  always @(negedge clk_in) begin
    if (rst_in && fetch_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", {31'b0, fetch_valid}, 32'h0);
      end else begin
        sb_e = sb_q.pop_front();
        check("rsp_ins", fetch_ins, sb_e.ins);
        check("rsp_pc", fetch_pc_out, sb_e.pc);
      end
    end
  end

  // Present a request, let it be accepted, and check whether a miss task starts.
  task automatic issue(input logic [31:0] pc, output logic hit);
    hit           = m_hit(pc);
    fetch_req     = 1'b1;
    fetch_pc      = pc;
    #1;
    check("ready", {31'b0, fetch_ready}, 32'h1);
    @(posedge clk_in); #1;
    fetch_req = 1'b0;
    if (hit) m_hits++;
    else     m_misses++;
    check("miss_start", {31'b0, try_start}, {31'b0, !hit});
  endtask

  // Adapter: keep try_start pending lat cycles, returning the word in the last one.
  task automatic complete(input logic [31:0] pc, input int lat);
    for (int i = 1; i < lat; i++) begin
      @(posedge clk_in); #1;
      check("ts_hold", {31'b0, try_start}, 32'h1);
    end
    insfetch_task_done = 1'b1;
    insfetch_ins_full  = mem_word(pc);
    @(posedge clk_in); #1;
    insfetch_task_done = 1'b0;
    check("miss_vld", {31'b0, fetch_valid}, 32'h1);
    check("ts_drop", {31'b0, try_start}, 32'h0);
    m_valid[m_idx(pc)] = 1'b1;
    m_tag[m_idx(pc)]   = pc >> (IDXB + 1);
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int lat);
    logic h;
    sb_q.push_back({mem_word(pc), pc});
    issue(pc, h);
    if (h) check("hit_vld", {31'b0, fetch_valid}, 32'h1);
    else   complete(pc, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"}, {31'b0, fetch_valid}, 32'h0);
    check({tag, "_ins"}, fetch_ins, 32'h0);
    check({tag, "_pc"}, fetch_pc_out, 32'h0);
    check({tag, "_addr"}, insfetch_addr, 32'h0);
    check({tag, "_ts"}, {31'b0, try_start}, 32'h0);
    check({tag, "_rdy"}, {31'b0, fetch_ready}, 32'h1);
`ifdef INS_CACHE_STATS_EN
    check({tag, "_hitc"}, hit_count, 32'h0);
    check({tag, "_missc"}, miss_count, 32'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'h0;
    end
    #3;
    check_reset_outputs("rst0");
    #9 rst_in = 1'b1;
    @(posedge clk_in); #1;

    // Cold miss, then back-to-back hits.
    do_fetch(32'h100, 4);
    do_fetch(32'h100, 0);
    do_fetch(32'h100, 0);

    // Compressed word and an aliasing PC on the same index.
    do_fetch(32'h102, 3);
    do_fetch(32'h102, 0);
    do_fetch(32'h102 + 2 * LINES, 5);
    do_fetch(32'h102, 4);
    do_fetch(32'h100, 0);

    // A request coinciding with flush is dropped.
    fetch_req     = 1'b1;
    fetch_pc      = 32'h100;
    flush_pipline = 1'b1;
    @(posedge clk_in); #1;
    fetch_req     = 1'b0;
    flush_pipline = 1'b0;
    check("flush_drop_vld", {31'b0, fetch_valid}, 32'h0);
    check("flush_drop_ts", {31'b0, try_start}, 32'h0);

    // Flush in the same cycle as done: result discarded, line not written.
    issue(32'h200, h);
    repeat (2) begin @(posedge clk_in); #1; end
    insfetch_task_done = 1'b1;
    insfetch_ins_full  = mem_word(32'h200);
    flush_pipline      = 1'b1;
    @(posedge clk_in); #1;
    insfetch_task_done = 1'b0;
    flush_pipline      = 1'b0;
    check("flushmiss_vld", {31'b0, fetch_valid}, 32'h0);
    check("flushmiss_rdy", {31'b0, fetch_ready}, 32'h1);
    check("flushmiss_ts", {31'b0, try_start}, 32'h0);
    do_fetch(32'h200, 3);

    // rdy_in low freezes the miss even with done pulses.
    sb_q.push_back({mem_word(32'h300), 32'h300});
    issue(32'h300, h);
    rdy_in             = 1'b0;
    insfetch_task_done = 1'b1;
    insfetch_ins_full  = 32'hDEAD_BEEF;
    repeat (3) begin
      @(posedge clk_in); #1;
      check("frz_ts", {31'b0, try_start}, 32'h1);
      check("frz_rdy", {31'b0, fetch_ready}, 32'h0);
      check("frz_vld", {31'b0, fetch_valid}, 32'h0);
    end
    rdy_in             = 1'b1;
    insfetch_task_done = 1'b0;
    complete(32'h300, 2);

    // Async reset between edges in the middle of a miss.
    do_fetch(32'h140, 3);
    issue(32'h400, h);
    #3 rst_in = 1'b0;
    #2;
    check_reset_outputs("arst");
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    @(posedge clk_in); #1;
    do_fetch(32'h140, 3);
    do_fetch(32'h140, 0);

    repeat (2) begin @(posedge clk_in); #1; end
    check("sb_empty", sb_q.size(), 32'h0);
`ifdef INS_CACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
